// File: rtl/scr1_tb_imem_responder.sv
// Bench-side SCR1 imem responder: preloadable word array, fixed-latency in-order OKAY/ERROR replies.
// Optional pseudo-random backpressure is enabled with SCR1_TB_IMEM_STALL_EN.
module scr1_tb_imem_responder #(
    parameter int          MEM_WORDS  = 1024,
    parameter int          LATENCY    = 1,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         imem_req,
    input  logic                         imem_cmd,
    input  logic [31:0]                  imem_addr,
    output logic                         imem_req_ack,
    output logic [31:0]                  imem_rdata,
    output logic [1:0]                   imem_resp,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [31:0]                  init_wdata,
    output logic [15:0]                  bge_count,
    output logic [7:0]                   err_count
);
    localparam int              IW      = $clog2(MEM_WORDS);
    localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0]      CD_INIT = 3'(LATENCY - 1);
    localparam logic [PW-1:0]   LAST    = PW'(FIFO_DEPTH - 1);

    logic [31:0]           mem [MEM_WORDS];
    logic [FIFO_DEPTH-1:0] vld_q, vld_d;
    logic [FIFO_DEPTH-1:0] err_q, err_d;
    logic [IW-1:0]         idx_q [FIFO_DEPTH];
    logic [IW-1:0]         idx_d [FIFO_DEPTH];
    logic [2:0]            cd_q  [FIFO_DEPTH];
    logic [2:0]            cd_d  [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            resp_q, resp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [15:0]           bge_q, bge_d;
    logic [7:0]            errc_q, errc_d;
    logic [31:0]           addr_off, word_off, head_word;
    logic                  req_err, accept, pop, stall;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef SCR1_TB_IMEM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        stall  = (lfsr_q[1:0] == 2'b00);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    // Slot at the write pointer still busy means the ring is full; a same-cycle pop does not help.
    assign imem_req_ack = rst_n & ~vld_q[wr_ptr_q] & ~stall;
    assign head_word    = mem[idx_q[rd_ptr_q]];

    always_comb begin
        addr_off = imem_addr - BASE_ADDR;
        word_off = addr_off >> 2;
        req_err  = imem_cmd | (imem_addr[1:0] != 2'b00) | (imem_addr < BASE_ADDR)
                 | (word_off >= 32'(MEM_WORDS));
        accept   = imem_req & imem_req_ack;
        pop      = vld_q[rd_ptr_q] & (cd_q[rd_ptr_q] == 3'd0);

        vld_d    = vld_q;
        err_d    = err_q;
        idx_d    = idx_q;
        cd_d     = cd_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        resp_d   = 2'b00;
        rdata_d  = 32'h0;
        bge_d    = bge_q;
        errc_d   = errc_q;

        for (int i = 0; i < FIFO_DEPTH; i++)
            if (vld_q[i] && cd_q[i] != 3'd0) cd_d[i] = cd_q[i] - 3'd1;

        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_nxt(rd_ptr_q);
            if (err_q[rd_ptr_q]) begin
                resp_d = 2'b10;
                if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
            end else begin
                resp_d  = 2'b01;
                rdata_d = head_word;
                if (head_word[6:0] == 7'b1100011 && head_word[14:12] == 3'b101 && bge_q != 16'hFFFF)
                    bge_d = bge_q + 16'd1;
            end
        end

        if (accept) begin
            vld_d[wr_ptr_q] = 1'b1;
            err_d[wr_ptr_q] = req_err;
            idx_d[wr_ptr_q] = word_off[IW-1:0];
            cd_d[wr_ptr_q]  = CD_INIT;
            wr_ptr_d        = ptr_nxt(wr_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            err_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            resp_q   <= 2'b00;
            rdata_q  <= 32'h0;
            bge_q    <= 16'h0;
            errc_q   <= 8'h0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                idx_q[i] <= '0;
                cd_q[i]  <= 3'd0;
            end
        end else begin
            vld_q    <= vld_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            cd_q     <= cd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
            bge_q    <= bge_d;
            errc_q   <= errc_d;
        end
    end

    // Array survives reset so preloaded images persist across core resets.
    always_ff @(posedge clk)
        if (init_we) mem[init_addr] <= init_wdata;

    assign imem_resp  = resp_q;
    assign imem_rdata = rdata_q;
    assign bge_count  = bge_q;
    assign err_count  = errc_q;
endmodule

// File: tb/tb_scr1_tb_imem_responder.sv
// Scoreboard bench for scr1_tb_imem_responder: directed reads/errors/reset plus a saturation run.
module tb_scr1_tb_imem_responder;
    localparam int MW = 16;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        imem_req = 0, imem_cmd = 0, init_we = 0;
    logic [31:0] imem_addr = 0, init_wdata = 0;
    logic [3:0]  init_addr = 0;
    logic        imem_req_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_resp;
    logic [15:0] bge_count;
    logic [7:0]  err_count;

    logic        s_req = 0, s_init_we = 0;
    logic [31:0] s_addr = 0, s_init_wdata = 0;
    logic [3:0]  s_init_addr = 0;
    logic        s_ack;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [15:0] s_bge;
    logic [7:0]  s_err;

    scr1_tb_imem_responder #(.MEM_WORDS(MW), .LATENCY(L), .FIFO_DEPTH(2), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_cmd(imem_cmd), .imem_addr(imem_addr),
        .imem_req_ack(imem_req_ack), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
        .bge_count(bge_count), .err_count(err_count));

    scr1_tb_imem_responder #(.MEM_WORDS(MW), .LATENCY(1), .FIFO_DEPTH(2), .BASE_ADDR(32'h1000)) u_sat (
        .clk(clk), .rst_n(rst_n), .imem_req(s_req), .imem_cmd(1'b0), .imem_addr(s_addr),
        .imem_req_ack(s_ack), .imem_rdata(s_rdata), .imem_resp(s_resp),
        .init_we(s_init_we), .init_addr(s_init_addr), .init_wdata(s_init_wdata),
        .bge_count(s_bge), .err_count(s_err));

    typedef struct {logic [1:0] resp; logic [31:0] data; int due;} exp_t;
    exp_t        sbq[$];
    int          n_chk = 0, n_fail = 0;
    logic [31:0] model [MW];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the queue head in code, data and arrival cycle.
    exp_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_resp != 2'b00) begin
                if (sbq.size() == 0) chk("unexpected_resp", {30'b0, imem_resp}, 32'h0);
                else begin
                    e = sbq.pop_front();
                    chk("resp_code", {30'b0, imem_resp}, {30'b0, e.resp});
                    chk("resp_data", imem_rdata, e.data);
                    chk("resp_cycle", cyc, e.due);
                end
            end else if (sbq.size() != 0 && sbq[0].due < cyc) begin
                chk("missing_resp", cyc, sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] d);
        init_we = 1; init_addr = 4'(idx); init_wdata = d;
        @(negedge clk);
        init_we = 0;
        model[idx] = d;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with imem_req still high.
    task automatic send(input logic cmd, input logic [31:0] addr);
        int n = 0;
        logic er;
        logic [31:0] idx_a;
        imem_req = 1; imem_cmd = cmd; imem_addr = addr;
        er = cmd || (addr[1:0] != 2'b00) || (addr >= 32'(4 * MW));
        idx_a = addr;
        #1;
        while (!imem_req_ack && n < 100) begin @(negedge clk); #1; n++; end
        if (!imem_req_ack) begin
            chk("ack_timeout", 32'h0, 32'h1);
            imem_req = 0;
            @(negedge clk);
            return;
        end
        sbq.push_back('{er ? 2'b10 : 2'b01, er ? 32'h0 : model[idx_a[5:2]], cyc + 1 + L});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        imem_req = 0; imem_cmd = 0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, guard;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, imem_req_ack}, 32'h0);
        chk("rst_resp", {30'b0, imem_resp}, 32'h0);
        chk("rst_rdata", imem_rdata, 32'h0);
        chk("rst_bge", {16'b0, bge_count}, 32'h0);
        chk("rst_err", {24'b0, err_count}, 32'h0);
        rst_n = 1;
        @(negedge clk);

        preload(0, 32'h0020D463);
        for (int i = 1; i <= 4; i++) preload(i, 32'(i));
        preload(5, 32'h0000_5063);
        preload(6, 32'h0000_0063);
        preload(15, 32'hCAFE_F00D);

        send(0, 32'h0); idle(L + 2);
        chk("bge_single", {16'b0, bge_count}, 32'd1);

        send(0, 32'h4); send(0, 32'h8); send(0, 32'hC); send(0, 32'h10);
        send(0, 32'h18); send(0, 32'h14); send(0, 32'h3C);
        idle(L + 3);
        chk("bge_stream", {16'b0, bge_count}, 32'd2);

        send(0, 32'h2); send(0, 32'h40); send(1, 32'h0);
        idle(L + 3);
        chk("err_count3", {24'b0, err_count}, 32'd3);
        send(0, 32'h0); idle(L + 2);
        chk("bge_after_err", {16'b0, bge_count}, 32'd3);

        // Overwrite word 1 at the very edge that registers its response: old data expected.
        send(0, 32'h4);
        imem_req = 0;
        repeat (L - 1) @(negedge clk);
        init_we = 1; init_addr = 4'd1; init_wdata = 32'h1111_1111;
        @(negedge clk);
        init_we = 0; model[1] = 32'h1111_1111;
        idle(L + 2);
        send(0, 32'h4); idle(L + 2);

        send(0, 32'h0); send(0, 32'h4);
        imem_req = 0;
        rst_n = 0;
        sbq.delete();
        @(negedge clk);
        chk("midrst_ack", {31'b0, imem_req_ack}, 32'h0);
        chk("midrst_resp", {30'b0, imem_resp}, 32'h0);
        rst_n = 1;
        idle(6);
        chk("post_rst_bge", {16'b0, bge_count}, 32'd0);
        chk("post_rst_err", {24'b0, err_count}, 32'd0);
        send(0, 32'h0); idle(L + 2);
        chk("post_rst_read_bge", {16'b0, bge_count}, 32'd1);
        chk("sb_drained", sbq.size(), 32'd0);

        // Saturation instance: one below-base error, then a stream of BGE reads past 16 bits.
        s_init_we = 1; s_init_addr = 0; s_init_wdata = 32'h0020D463;
        @(negedge clk);
        s_init_we = 0;
        s_req = 1; s_addr = 32'h0FFC;
        #1; guard = 0;
        while (!s_ack && guard < 100) begin @(negedge clk); #1; guard++; end
        chk("sat_err_ack", {31'b0, s_ack}, 32'h1);
        @(negedge clk);
        s_addr = 32'h1000;
        acc = 0; guard = 0;
        while (acc < 65537 && guard < 90000) begin
            #1;
            if (s_ack) acc++;
            guard++;
            @(negedge clk);
        end
        s_req = 0;
        chk("sat_accepts", acc, 32'd65537);
        repeat (4) @(negedge clk);
        chk("sat_bge", {16'b0, s_bge}, 32'h0000_FFFF);
        chk("sat_err", {24'b0, s_err}, 32'd1);
        chk("sat_idle_resp", {30'b0, s_resp}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
